// File: rtl/stream_stage_pkg.sv
// rtl/stream_stage_pkg.sv - shared mode codes, FSM states and token layout for stream stages
package stream_stage_pkg;

    localparam logic [1:0] MODE_PASS = 2'd0;
    localparam logic [1:0] MODE_BFLY = 2'd1;
    localparam logic [1:0] MODE_REV  = 2'd2;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_e;

    // Reference token layout at the default 9-bit lane width; eos flag sits above the data.
    localparam int TOKEN_WIDTH = 9;

    typedef struct packed {
        logic                   e;
        logic [TOKEN_WIDTH-1:0] d;
    } token_t;

endpackage

// File: rtl/stream_lane_fifo.sv
// rtl/stream_lane_fifo.sv - single-lane output FIFO with occupancy count
module stream_lane_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Empty FIFO presents zero so the lane output is clean after reset.
    assign data_o  = empty_o ? '0 : mem_q[rd_q];

    always_comb begin
        rd_d  = do_pop  ? ptr_next(rd_q) : rd_q;
        wr_d  = do_push ? ptr_next(wr_q) : wr_q;
        cnt_d = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

endmodule

// File: rtl/stream_butterfly_stage.sv
// rtl/stream_butterfly_stage.sv - all-lane join, mode-selected lane operation, per-lane output FIFOs
module stream_butterfly_stage
    import stream_stage_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int LANES = 8,
    parameter int DEPTH = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [1:0]             mode,
    input  logic [LANES*WIDTH-1:0] in_d,
    input  logic [LANES-1:0]       in_e,
    input  logic [LANES-1:0]       in_v,
    output logic [LANES-1:0]       in_b,
    output logic [LANES*WIDTH-1:0] out_d,
    output logic [LANES-1:0]       out_e,
    output logic [LANES-1:0]       out_v,
    input  logic [LANES-1:0]       out_b,
    output logic                   err
);

    localparam int H  = LANES / 2;
    localparam int CW = $clog2(DEPTH + 1);

    state_e           state_q, state_d;
    logic             active_q, active_d;
    logic [1:0]       mode_q, mode_d;
    logic             err_q, err_d;

    logic [LANES-1:0] full, empty, space_l;
    logic [CW-1:0]    cnt [LANES];
    logic [WIDTH-1:0] x [LANES];
    logic [WIDTH-1:0] y [LANES];
    logic [WIDTH:0]   push_tok [LANES];
    logic [WIDTH:0]   head_tok [LANES];
    logic [1:0]       cur_mode;
    logic             fire, eos_any, eos_all;

    // Reset gates the join so nothing is accepted while reset is held.
    assign fire     = reset & (state_q == RUN) & (&in_v) & (&space_l);
    assign eos_any  = |in_e;
    assign eos_all  = &in_e;
    assign cur_mode = active_q ? mode_q : mode;
    assign in_b     = {LANES{~fire}};
    assign err      = err_q;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            x[i]       = in_d[i*WIDTH +: WIDTH];
            space_l[i] = (cnt[i] < CW'(DEPTH));
        end
        y = x;
        case (cur_mode)
            MODE_BFLY: begin
                for (int i = 0; i < H; i++) begin
                    y[i]     = x[i] + x[i+H];
                    y[i + H] = x[i] - x[i+H];
                end
            end
            MODE_REV: begin
                for (int i = 0; i < LANES; i++) begin
                    y[i] = x[LANES-1-i];
                end
            end
            default: y = x;
        endcase
        for (int i = 0; i < LANES; i++) begin
            push_tok[i] = eos_any ? {1'b1, {WIDTH{1'b0}}} : {1'b0, y[i]};
        end
    end

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        mode_d   = mode_q;
        err_d    = err_q;
        case (state_q)
            RUN: begin
                if (fire) begin
                    if (!active_q) begin
                        mode_d   = mode;
                        active_d = 1'b1;
                    end
                    if (eos_any) begin
                        state_d = DRAIN;
                        if (!eos_all) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            DRAIN: begin
                if (&empty) begin
                    state_d  = RUN;
                    active_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= RUN;
            active_q <= 1'b0;
            mode_q   <= MODE_PASS;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            mode_q   <= mode_d;
            err_q    <= err_d;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        stream_lane_fifo #(
            .WIDTH (WIDTH + 1),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk_i   (clock),
            .rst_ni  (reset),
            .push_i  (fire & ~full[g]),
            .data_i  (push_tok[g]),
            .pop_i   (~empty[g] & ~out_b[g]),
            .data_o  (head_tok[g]),
            .count_o (cnt[g]),
            .full_o  (full[g]),
            .empty_o (empty[g])
        );
        assign out_v[g]                 = ~empty[g];
        assign out_e[g]                 = head_tok[g][WIDTH];
        assign out_d[g*WIDTH +: WIDTH]  = head_tok[g][WIDTH-1:0];
    end

endmodule

// File: tb/tb_stream_butterfly_stage.sv
// tb/tb_stream_butterfly_stage.sv - directed self-checking bench for stream_butterfly_stage
module tb_stream_butterfly_stage;
    import stream_stage_pkg::*;

    localparam int W = 9;
    localparam int L = 8;
    localparam int D = 2;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic [1:0]     mode;
    logic [L*W-1:0] in_d;
    logic [L-1:0]   in_e, in_v, in_b;
    logic [L*W-1:0] out_d;
    logic [L-1:0]   out_e, out_v, out_b;
    logic           err;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] vals [L];

    stream_butterfly_stage #(.WIDTH(W), .LANES(L), .DEPTH(D)) dut (
        .clock (clock),
        .reset (reset),
        .mode  (mode),
        .in_d  (in_d),
        .in_e  (in_e),
        .in_v  (in_v),
        .in_b  (in_b),
        .out_d (out_d),
        .out_e (out_e),
        .out_v (out_v),
        .out_b (out_b),
        .err   (err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic load();
        for (int i = 0; i < L; i++) in_d[i*W +: W] = vals[i];
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    function automatic logic [W-1:0] lane(input int i);
        token_t t;
        t = token_t'({out_e[i], out_d[i*W +: W]});
        return t.d;
    endfunction

    initial begin
        mode = 2'd0; in_d = '0; in_e = '0; in_v = '0; out_b = '0;
        #2;
        check("rst_out_v", 32'(out_v), 32'h00);
        check("rst_out_d", 32'(|out_d), 32'd0);
        check("rst_out_e", 32'(out_e), 32'h00);
        check("rst_in_b",  32'(in_b),  32'hff);
        check("rst_err",   32'(err),   32'd0);
        @(negedge clock);
        reset = 1'b1;

        // butterfly stream
        vals = '{9'd200, 9'd1, 9'd2, 9'd3, 9'd100, 9'd5, 9'd6, 9'd7};
        load(); mode = 2'd1; in_v = 8'hff;
        #1 check("bfly_fire_in_b", 32'(in_b), 32'h00);
        tick();
        in_v = '0;
        check("bfly_out_v", 32'(out_v), 32'hff);
        check("bfly_l0", 32'(lane(0)), 32'd300);
        check("bfly_l4", 32'(lane(4)), 32'd100);
        check("bfly_l1", 32'(lane(1)), 32'd6);
        check("bfly_l5", 32'(lane(5)), 32'd508);
        check("bfly_l6", 32'(lane(6)), 32'd508);
        tick();
        check("bfly_popped", 32'(out_v), 32'h00);

        // end of stream, next stream data already waiting
        in_v = 8'hff; in_e = 8'hff;
        tick();
        in_e = '0; mode = 2'd2;
        for (int i = 0; i < L; i++) vals[i] = W'(i);
        load();
        check("eos_out_v", 32'(out_v), 32'hff);
        check("eos_out_e", 32'(out_e), 32'hff);
        check("eos_out_d", 32'(|out_d), 32'd0);
        check("eos_drain_in_b", 32'(in_b), 32'hff);
        check("eos_err", 32'(err), 32'd0);
        tick();
        check("drain_empty_v", 32'(out_v), 32'h00);
        check("drain_still_b", 32'(in_b), 32'hff);
        tick();
        check("run_again_in_b", 32'(in_b), 32'h00);

        // reverse stream; mode flip mid-stream is ignored
        tick();
        mode = 2'd0;
        for (int i = 0; i < L; i++) vals[i] = W'(10 + i);
        load();
        check("rev_l0", 32'(lane(0)), 32'd7);
        check("rev_l3", 32'(lane(3)), 32'd4);
        check("rev_l7", 32'(lane(7)), 32'd0);
        tick();
        in_v = '0;
        check("rev2_l0", 32'(lane(0)), 32'd17);
        check("rev2_l7", 32'(lane(7)), 32'd10);
        tick();
        check("rev_idle", 32'(out_v), 32'h00);

        // back-pressure on lane 3
        out_b = 8'h08; in_v = 8'hff;
        for (int i = 0; i < L; i++) vals[i] = 9'd20;
        load();
        #1 check("bp_fire1", 32'(in_b), 32'h00);
        tick();
        for (int i = 0; i < L; i++) vals[i] = 9'd21;
        load();
        check("bp_fire2", 32'(in_b), 32'h00);
        tick();
        for (int i = 0; i < L; i++) vals[i] = 9'd22;
        load();
        check("bp_stall", 32'(in_b), 32'hff);
        tick();
        check("bp_stall2", 32'(in_b), 32'hff);
        check("bp_only_l3", 32'(out_v), 32'h08);
        check("bp_l3_head", 32'(lane(3)), 32'd20);
        out_b = '0;
        #1 check("bp_no_passthru", 32'(in_b), 32'hff);
        tick();
        check("bp_release", 32'(in_b), 32'h00);
        check("bp_l3_head2", 32'(lane(3)), 32'd21);
        tick();
        in_v = '0;
        check("bp_fire3_v", 32'(out_v), 32'hff);
        check("bp_fire3_l0", 32'(lane(0)), 32'd22);
        check("bp_fire3_l3", 32'(lane(3)), 32'd22);
        tick();
        check("bp_idle", 32'(out_v), 32'h00);

        // lane skew: lane 6 absent
        in_v = 8'hbf;
        for (int k = 0; k < 4; k++) begin
            #1 check("skew_in_b", 32'(in_b), 32'hff);
            tick();
            check("skew_no_out", 32'(out_v), 32'h00);
        end
        in_v = '0;

        // mismatched eos
        in_v = 8'hff; in_e = 8'h01;
        tick();
        in_v = '0; in_e = '0;
        check("mm_err", 32'(err), 32'd1);
        check("mm_out_v", 32'(out_v), 32'hff);
        check("mm_out_e", 32'(out_e), 32'hff);
        tick();
        tick();
        for (int i = 0; i < L; i++) vals[i] = W'(30 + i);
        load(); in_v = 8'hff;
        tick();
        in_v = '0;
        check("mm_sticky", 32'(err), 32'd1);
        check("mm_next_v", 32'(out_v), 32'hff);
        check("mm_next_pass", 32'(lane(2)), 32'd32);

        // reset in the middle of a drain
        in_v = 8'hff; in_e = 8'hff; out_b = 8'hff;
        tick();
        in_v = '0; in_e = '0;
        check("pre_rst_v", 32'(out_v), 32'hff);
        #2 reset = 1'b0;
        #1;
        check("async_rst_v", 32'(out_v), 32'h00);
        check("async_rst_err", 32'(err), 32'd0);
        check("async_rst_in_b", 32'(in_b), 32'hff);
        @(negedge clock);
        reset = 1'b1; out_b = '0;
        tick();
        check("post_rst_v", 32'(out_v), 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/stream_butterfly_stage.md
Name: stream_butterfly_stage

Overview:
Parametrised successor to the fixed 8-in/8-out JPEG-decode stream operators. It joins LANES token streams and fires only when every lane holds a token. Each firing applies a mode-selected lane operation (pass, butterfly add/sub, or lane reversal) and pushes one result per lane into independent per-lane output FIFOs. It sits between IDCT/reorder stages in the decode pipeline and propagates end-of-stream tokens across all lanes, with a drain phase between streams.

Parameters:
WIDTH, 9, data bits per lane token.
LANES, 8, lane count; even, at least 2.
DEPTH, 2, per-lane output FIFO depth; at least 1.

Ports:
clock  in  1  single clock, rising edge.
reset  in  1  asynchronous, active-low reset.
mode  in  2  0 = pass, 1 = butterfly, 2 = reverse, 3 = reserved (treated as pass); sampled only at stream start.
in_d  in  LANES*WIDTH  lane i data at bits [i*WIDTH +: WIDTH].
in_e  in  LANES  end-of-stream flag per lane token.
in_v  in  LANES  token valid per lane.
in_b  out  LANES  back-pressure per lane; a token is consumed when in_v[i] is high and in_b[i] is low.
out_d  out  LANES*WIDTH  output data, same packing as in_d.
out_e  out  LANES  end-of-stream flag per output token.
out_v  out  LANES  output valid per lane.
out_b  in  LANES  downstream back-pressure; a token is popped when out_v[i] is high and out_b[i] is low.
err  out  1  sticky flag for an end-of-stream mismatch across lanes.

Behaviour:
- Reset (reset low, asynchronous):
  - All FIFOs empty; out_v = 0, out_d = 0, out_e = 0.
  - in_b = all ones; err = 0; state = RUN; active = 0; mode_q = 0.
- space = every lane FIFO count < DEPTH. There is no same-cycle pass-through when full; a pop frees space for the next cycle.
- fire = (state == RUN) & (all in_v high) & space.
  - in_b[i] = ~fire for every lane, so partial consumption never occurs.
- Mode selection:
  - On a firing with active = 0, use the mode port, load mode_q from it, and set active = 1.
  - On later firings, use mode_q. Mid-stream changes to the mode port are ignored.
- Data firing (no in_e set). Operands are the input lanes x[0..LANES-1]; H = LANES/2.
  - pass: y[i] = x[i].
  - butterfly: for i < H, y[i] = x[i] + x[i+H] and y[i+H] = x[i] - x[i+H]. Results are modulo 2^WIDTH (wrap, no saturation).
  - reverse: y[i] = x[LANES-1-i].
  - Each y[i] is pushed with e = 0.
- End-of-stream firing:
  - If all in_e are high: push data 0 with e = 1 on every lane, then go to DRAIN.
  - If in_e is mixed: same action as all-high, and additionally set err = 1.
  - err is cleared only by reset.
- DRAIN state: in_b all ones. When all FIFOs are empty, go to RUN and clear active.
- Latency: a firing at edge k makes out_v visible after edge k. Throughput is 1 firing per cycle while no lane is back-pressured.
- Output FIFOs:
  - out_v[i] = FIFO i non-empty; out_d and out_e show the head entry.
  - Lanes drain independently.
  - Push and pop in the same cycle on a non-full FIFO keep its count unchanged.
- Reset asserted mid-stream discards all buffered tokens. No eos token is emitted.

Decomposition:
- Package stream_stage_pkg holds:
  - the mode constants MODE_PASS, MODE_BFLY, MODE_REV;
  - the state enum {RUN, DRAIN};
  - a token struct {e, d}.
- Sub-module stream_lane_fifo (WIDTH+1 bits wide, DEPTH deep, push/pop/count/full/empty), instantiated LANES times via generate.
- The top level holds the join/fire logic, the mode mux, and the FSM.

Test Plan:
- Butterfly, defaults, mode = 1. Lanes 0..7 = 200, 1, 2, 3, 100, 5, 6, 7 → out lane 0 = 300, lane 4 = 100, lane 1 = 6, lane 5 = 508 (1 - 5 wraps). out_v high one cycle after the firing.
- Reverse, mode = 2, lanes = 0..7 → out = 7..0. Flip the mode port to 0 mid-stream → the next token is still reversed.
- Back-pressure:
  - Hold out_b[3] = 1 and push 3 tokens → the 3rd firing stalls (in_b all 1) once lane 3 holds DEPTH = 2 entries.
  - Other lanes drain their 2 tokens.
  - Release out_b[3] → the 3rd firing occurs the cycle after lane 3's first pop.
- Lane skew: drop in_v[6] for 4 cycles while the other lanes are valid → no tokens consumed on any lane and in_b = all ones.
- End of stream:
  - All in_e = 1 → 8 eos tokens with data 0; in_b stays high until all FIFOs are empty.
  - Then the next stream starts and picks up the new mode value.
- Mismatch and reset:
  - in_e = 0x01 → eos emitted on all lanes and err = 1 (sticky through the next stream).
  - Assert reset mid-drain → out_v = 0 and err = 0 immediately, with no clock edge required.
